// File: rtl/adc_align_pkg.sv
// Shared types and constants for the ADC word aligner.
//   chan_state_e : per-channel alignment FSM state
//   ERR_W        : width of the per-channel error counter
//   max_tries()  : number of failed compares before a channel gives up
package adc_align_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StVerify,
    StLocked
  } chan_state_e;

  localparam int unsigned ERR_W = 8;

  // Every offset is tried twice before the search is abandoned.
  function automatic int unsigned max_tries(input int unsigned width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/adc_align_chan.sv
// One channel of the ADC word aligner: two-word history, barrel select, alignment FSM
// and optional error counter.
//   clk_i, rst_ni     : word clock, async active-low reset
//   align_i           : restart alignment
//   train_i           : training pattern present, enables compares
//   din_i             : raw deserialized word
//   dout_o            : word at the selected offset (registered)
//   offset_o          : current shift
//   locked_o, fail_o  : lock / search-exhausted flags
//   err_cnt_o         : saturating mismatch count while locked (ADC_ALIGN_ERRCNT_EN), else 0
module adc_align_chan
  import adc_align_pkg::*;
#(
  parameter int unsigned     WIDTH     = 12,
  parameter logic [WIDTH-1:0] TRAIN_PAT = 12'hFC0,
  parameter int unsigned     MATCH_CNT = 16,
  parameter int unsigned     SHW       = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             align_i,
  input  logic             train_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [SHW-1:0]   offset_o,
  output logic             locked_o,
  output logic             fail_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  localparam int unsigned MaxTries = max_tries(WIDTH);
  localparam int unsigned TryW     = $clog2(MaxTries + 1);
  localparam int unsigned MatchW   = $clog2(MATCH_CNT + 1);

  chan_state_e         state_q;
  logic [WIDTH-1:0]    r0_q, r1_q, dout_q;
  logic [SHW-1:0]      offset_q;
  logic [TryW-1:0]     tries_q;
  logic [MatchW-1:0]   match_q;
  logic                locked_q, fail_q;

  logic [2*WIDTH-1:0]  window;
  logic [WIDTH-1:0]    cand;
  logic                hit;
  logic [SHW-1:0]      offset_inc;
  logic [TryW-1:0]     tries_inc;
  logic [MatchW-1:0]   match_inc;

  // Older word in the MSBs, so offset k pulls k bits from the previous word.
  assign window     = {r1_q, r0_q};
  assign cand       = window[offset_q +: WIDTH];
  assign hit        = (cand == TRAIN_PAT);
  assign offset_inc = (offset_q == SHW'(WIDTH - 1)) ? '0 : offset_q + 1'b1;
  assign tries_inc  = tries_q + 1'b1;
  assign match_inc  = match_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      r0_q     <= '0;
      r1_q     <= '0;
      dout_q   <= '0;
      offset_q <= '0;
      tries_q  <= '0;
      match_q  <= '0;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      r0_q   <= din_i;
      r1_q   <= r0_q;
      dout_q <= cand;
      if (align_i) begin
        state_q  <= StSearch;
        offset_q <= '0;
        tries_q  <= '0;
        match_q  <= '0;
        locked_q <= 1'b0;
        fail_q   <= 1'b0;
      end else begin
        case (state_q)
          StSearch: begin
            if (train_i) begin
              if (hit) begin
                match_q <= MatchW'(1);
                state_q <= StVerify;
              end else begin
                offset_q <= offset_inc;
                tries_q  <= tries_inc;
                if (tries_inc == TryW'(MaxTries)) begin
                  fail_q  <= 1'b1;
                  state_q <= StIdle;
                end
              end
            end
          end
          StVerify: begin
            if (train_i) begin
              if (hit) begin
                match_q <= match_inc;
                if (match_inc == MatchW'(MATCH_CNT)) begin
                  state_q  <= StLocked;
                  locked_q <= 1'b1;
                end
              end else begin
                match_q  <= '0;
                offset_q <= offset_inc;
                tries_q  <= tries_inc;
                if (tries_inc == TryW'(MaxTries)) begin
                  fail_q  <= 1'b1;
                  state_q <= StIdle;
                end else begin
                  state_q <= StSearch;
                end
              end
            end
          end
          StIdle, StLocked: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef ADC_ALIGN_ERRCNT_EN
  logic [ERR_W-1:0] err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= '0;
    end else if (align_i) begin
      err_q <= '0;
    end else if (state_q == StLocked && train_i && !hit && err_q != '1) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign err_cnt_o = err_q;
`else
  assign err_cnt_o = '0;
`endif

  assign dout_o   = dout_q;
  assign offset_o = offset_q;
  assign locked_o = locked_q;
  assign fail_o   = fail_q;

endmodule

// File: rtl/adc_word_aligner.sv
// Multi-channel ADC word aligner. Finds each channel's word boundary against a training
// pattern via a soft barrel shift over two consecutive words, then holds lock.
// Optional per-channel error counter: define ADC_ALIGN_ERRCNT_EN.
//   FRAME_CLK, RST_N : word clock, async active-low reset
//   ALIGN, TRAIN     : restart pulse, training-pattern-present
//   DIN / DOUT       : raw / aligned words, channel c at [c*WIDTH +: WIDTH]
//   OFFSET           : per-channel shift, LOCKED / FAIL per channel
//   ALL_LOCKED       : registered AND of LOCKED; DVALID: registered all-locked and not TRAIN
//   ERR_CNT          : per-channel 8-bit error counter
module adc_word_aligner
  import adc_align_pkg::*;
#(
  parameter int unsigned      NCHAN     = 8,
  parameter int unsigned      WIDTH     = 12,
  parameter logic [WIDTH-1:0] TRAIN_PAT = 12'hFC0,
  parameter int unsigned      MATCH_CNT = 16,
  parameter int unsigned      SHW       = $clog2(WIDTH)
) (
  input  logic                   FRAME_CLK,
  input  logic                   RST_N,
  input  logic                   ALIGN,
  input  logic                   TRAIN,
  input  logic [NCHAN*WIDTH-1:0] DIN,
  output logic [NCHAN*WIDTH-1:0] DOUT,
  output logic                   DVALID,
  output logic [NCHAN*SHW-1:0]   OFFSET,
  output logic [NCHAN-1:0]       LOCKED,
  output logic                   ALL_LOCKED,
  output logic [NCHAN-1:0]       FAIL,
  output logic [NCHAN*ERR_W-1:0] ERR_CNT
);

  logic all_locked_q, dvalid_q;

  for (genvar c = 0; c < NCHAN; c++) begin : gen_chan
    adc_align_chan #(
      .WIDTH    (WIDTH),
      .TRAIN_PAT(TRAIN_PAT),
      .MATCH_CNT(MATCH_CNT),
      .SHW      (SHW)
    ) u_chan (
      .clk_i    (FRAME_CLK),
      .rst_ni   (RST_N),
      .align_i  (ALIGN),
      .train_i  (TRAIN),
      .din_i    (DIN[c*WIDTH +: WIDTH]),
      .dout_o   (DOUT[c*WIDTH +: WIDTH]),
      .offset_o (OFFSET[c*SHW +: SHW]),
      .locked_o (LOCKED[c]),
      .fail_o   (FAIL[c]),
      .err_cnt_o(ERR_CNT[c*ERR_W +: ERR_W])
    );
  end

  always_ff @(posedge FRAME_CLK or negedge RST_N) begin
    if (!RST_N) begin
      all_locked_q <= 1'b0;
      dvalid_q     <= 1'b0;
    end else begin
      all_locked_q <= &LOCKED;
      dvalid_q     <= (&LOCKED) & ~TRAIN;
    end
  end

  assign ALL_LOCKED = all_locked_q;
  assign DVALID     = dvalid_q;

endmodule

// File: tb/tb_adc_word_aligner.sv
// Directed bench for adc_word_aligner with two 12-bit channels.
// Streams are constant rotations of the training word: rol(FC0,5)=81F sits at offset 5,
// rol(FC0,9)=1F8 at offset 9.
module tb_adc_word_aligner;

  localparam int unsigned NCHAN = 2;
  localparam int unsigned WIDTH = 12;
  localparam int unsigned SHW   = 4;

  logic                   FRAME_CLK = 1'b0;
  logic                   RST_N;
  logic                   ALIGN;
  logic                   TRAIN;
  logic [NCHAN*WIDTH-1:0] DIN;
  logic [NCHAN*WIDTH-1:0] DOUT;
  logic                   DVALID;
  logic [NCHAN*SHW-1:0]   OFFSET;
  logic [NCHAN-1:0]       LOCKED;
  logic                   ALL_LOCKED;
  logic [NCHAN-1:0]       FAIL;
  logic [NCHAN*8-1:0]     ERR_CNT;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef ADC_ALIGN_ERRCNT_EN
  localparam logic [15:0] Err3   = 16'h0003;
  localparam logic [15:0] ErrSat = 16'h00FF;
`else
  localparam logic [15:0] Err3   = 16'h0000;
  localparam logic [15:0] ErrSat = 16'h0000;
`endif

  adc_word_aligner #(
    .NCHAN    (NCHAN),
    .WIDTH    (WIDTH),
    .TRAIN_PAT(12'hFC0),
    .MATCH_CNT(16)
  ) dut (
    .FRAME_CLK (FRAME_CLK),
    .RST_N     (RST_N),
    .ALIGN     (ALIGN),
    .TRAIN     (TRAIN),
    .DIN       (DIN),
    .DOUT      (DOUT),
    .DVALID    (DVALID),
    .OFFSET    (OFFSET),
    .LOCKED    (LOCKED),
    .ALL_LOCKED(ALL_LOCKED),
    .FAIL      (FAIL),
    .ERR_CNT   (ERR_CNT)
  );

  always #5 FRAME_CLK = ~FRAME_CLK;

  task automatic tick();
    @(posedge FRAME_CLK);
    #1;
  endtask

  task automatic pulse_align();
    ALIGN = 1'b1;
    tick();
    ALIGN = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"}, 64'(DOUT), 64'h0);
    check({tag, "_locked"}, 64'(LOCKED), 64'h0);
    check({tag, "_all_locked"}, 64'(ALL_LOCKED), 64'h0);
    check({tag, "_dvalid"}, 64'(DVALID), 64'h0);
    check({tag, "_offset"}, 64'(OFFSET), 64'h0);
    check({tag, "_fail"}, 64'(FAIL), 64'h0);
    check({tag, "_err"}, 64'(ERR_CNT), 64'h0);
  endtask

  initial begin
    RST_N = 1'b0;
    ALIGN = 1'b0;
    TRAIN = 1'b1;
    DIN   = {12'h81F, 12'hFC0};
    #12;
    check_all_zero("reset_init");
    RST_N = 1'b1;

    // No ALIGN: nothing locks, DOUT follows offset 0.
    repeat (20) tick();
    check("no_align_locked", 64'(LOCKED), 64'h0);
    check("no_align_fail", 64'(FAIL), 64'h0);
    check("pre_lock_dout", 64'(DOUT), 64'h81F_FC0);

    // Alignment: ch0 at offset 0, ch1 at offset 5.
    pulse_align();  // edge a
    check("align_offset0", 64'(OFFSET), 64'h00);
    check("align_locked0", 64'(LOCKED), 64'h0);
    repeat (15) tick();
    check("lock_a15", 64'(LOCKED), 64'h0);
    tick();
    check("lock_a16", 64'(LOCKED), 64'h1);
    check("offset_a16", 64'(OFFSET), 64'h50);
    repeat (4) tick();
    check("lock_a20", 64'(LOCKED), 64'h1);
    tick();
    check("lock_a21", 64'(LOCKED), 64'h3);
    check("all_locked_a21", 64'(ALL_LOCKED), 64'h0);
    tick();
    check("all_locked_a22", 64'(ALL_LOCKED), 64'h1);
    check("dvalid_train", 64'(DVALID), 64'h0);
    check("dout_aligned", 64'(DOUT), 64'hFC0_FC0);
    TRAIN = 1'b0;
    tick();
    check("dvalid_no_train", 64'(DVALID), 64'h1);
    TRAIN = 1'b1;

    // Corrupted words while locked.
    DIN = {12'h81F, 12'h000};
    repeat (3) tick();
    DIN = {12'h81F, 12'hFC0};
    repeat (3) tick();
    check("err_cnt_3", 64'(ERR_CNT), 64'(Err3));
    check("err_still_locked", 64'(LOCKED), 64'h3);
    DIN = {12'h81F, 12'h000};
    repeat (300) tick();
    DIN = {12'h81F, 12'hFC0};
    repeat (3) tick();
    check("err_cnt_sat", 64'(ERR_CNT), 64'(ErrSat));
    check("err_sat_locked", 64'(LOCKED), 64'h3);

    // Restart with ch0 re-shifted to offset 9.
    DIN = {12'h81F, 12'h1F8};
    repeat (2) tick();
    pulse_align();  // edge b
    check("restart_locked", 64'(LOCKED), 64'h0);
    check("restart_err", 64'(ERR_CNT), 64'h0);
    check("restart_offset", 64'(OFFSET), 64'h00);
    repeat (20) tick();
    check("restart_b20", 64'(LOCKED), 64'h0);
    tick();
    check("restart_b21", 64'(LOCKED), 64'h2);
    repeat (3) tick();
    check("restart_b24", 64'(LOCKED), 64'h2);
    tick();
    check("restart_b25", 64'(LOCKED), 64'h3);
    check("restart_offset9", 64'(OFFSET), 64'h59);

    // Failure: ch0 never shows the pattern.
    DIN = {12'h81F, 12'h000};
    repeat (2) tick();
    pulse_align();  // edge f
    repeat (23) tick();
    check("fail_f23", 64'(FAIL), 64'h0);
    tick();
    check("fail_f24", 64'(FAIL), 64'h1);
    check("fail_locked", 64'(LOCKED), 64'h2);
    pulse_align();
    check("fail_cleared", 64'(FAIL), 64'h0);

    // Freeze: TRAIN low during SEARCH holds offset and tries.
    DIN = {12'h81F, 12'h1F8};
    repeat (2) tick();
    pulse_align();  // edge g
    repeat (3) tick();
    check("freeze_offset_pre", 64'(OFFSET), 64'h33);
    TRAIN = 1'b0;
    repeat (10) tick();
    check("freeze_offset", 64'(OFFSET), 64'h33);
    check("freeze_locked", 64'(LOCKED), 64'h0);
    TRAIN = 1'b1;
    repeat (17) tick();
    check("freeze_t17", 64'(LOCKED), 64'h0);
    tick();
    check("freeze_t18", 64'(LOCKED), 64'h2);
    repeat (3) tick();
    check("freeze_t21", 64'(LOCKED), 64'h2);
    tick();
    check("freeze_t22", 64'(LOCKED), 64'h3);
    check("freeze_offset_lock", 64'(OFFSET), 64'h59);

    // Glitch at match=8: ch0 walks all offsets once more and needs a full MATCH_CNT.
    DIN = {12'h81F, 12'hFC0};
    repeat (2) tick();
    pulse_align();  // edge h
    repeat (7) tick();
    DIN = {12'h81F, 12'h000};
    tick();
    DIN = {12'h81F, 12'hFC0};
    tick();  // h+9
    check("glitch_offset", 64'(OFFSET[3:0]), 64'h1);
    check("glitch_locked", 64'(LOCKED[0]), 64'h0);
    repeat (26) tick();
    check("glitch_h35", 64'(LOCKED[0]), 64'h0);
    tick();
    check("glitch_h36", 64'(LOCKED[0]), 64'h1);
    check("glitch_offset_lock", 64'(OFFSET[3:0]), 64'h0);

    // Asynchronous reset mid-stream.
    repeat (2) tick();
    check("pre_reset_all_locked", 64'(ALL_LOCKED), 64'h1);
    #3;
    RST_N = 1'b0;
    #1;
    check_all_zero("reset_async");
    #3;
    RST_N = 1'b1;
    repeat (30) tick();
    check("post_reset_locked", 64'(LOCKED), 64'h0);
    check("post_reset_offset", 64'(OFFSET), 64'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
